// File: rtl/rca_seq_ctrl_pkg.sv
// rtl/rca_seq_ctrl_pkg.sv - shared constants and state encoding for the nibble-serial add/sub sequencer
// Purpose: state encoding, nibble width and default operand size used by rca_seq_ctrl.
// Ports: none (package).
package rca_seq_ctrl_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int NIBBLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_1.sv
// rtl/full_adder_1.sv - one-bit full adder
// Purpose: single-bit sum and carry from two operand bits and a carry-in.
// Ports: a, b, cin (in); s, cout (out).
module full_adder_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_4.sv
// rtl/rca_4.sv - four-bit ripple-carry adder built from full_adder_1
// Purpose: purely combinational 4-bit add with carry-in and carry-out.
// Ports: a[3:0], b[3:0], cin (in); s[3:0], cout (out).
module rca_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder_1 u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[4];

endmodule

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - nibble-serial W-bit add/sub sequencer around one shared rca_4
// Purpose: accepts an operand pair on start&&ready, adds one nibble per cycle LSB first
//          through a single rca_4, then presents sum/cout/ovf with a one-cycle done pulse.
// Ports: clk, rst_n (sync, active-low), start, sub, a[W-1:0], b[W-1:0] (in);
//        ready, busy, done, sum[W-1:0], cout, ovf (out).
module rca_seq_ctrl
  import rca_seq_ctrl_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT,
  localparam int W      = NIBBLE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int             IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NIBBLES - 1);

  state_t                state, state_next;
  logic [IW-1:0]         idx;
  logic                  carry;
  logic [W-1:0]          opa, opb, work, work_next;
  logic [W-1:0]          sum_q;
  logic                  cout_q, ovf_q;
  logic [NIBBLE_W-1:0]   nib_a, nib_b, nib_s;
  logic                  nib_cout;
  logic                  accept;

  assign accept = start && ready;

  assign nib_a = opa[NIBBLE_W*idx +: NIBBLE_W];
  assign nib_b = opb[NIBBLE_W*idx +: NIBBLE_W];

  rca_4 u_rca (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // Work register with the current nibble already merged, so the final
  // sum captured on the RUN->DONE edge includes the last nibble.
  always_comb begin
    work_next = work;
    work_next[NIBBLE_W*idx +: NIBBLE_W] = nib_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    begin ready = 1'b1; done = 1'b1; end
      default: ready = 1'b0;
    endcase
  end

  // Datapath: operand capture, nibble stepping and result latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      work   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
      opa   <= a;
      opb   <= sub ? ~b : b;
      carry <= sub;
      idx   <= '0;
    end else if (state == RUN) begin
      work  <= work_next;
      carry <= nib_cout;
      idx   <= idx + 1'b1;
      if (idx == LAST_IDX) begin
        sum_q  <= work_next;
        cout_q <= nib_cout;
        ovf_q  <= (opa[W-1] == opb[W-1]) && (nib_s[NIBBLE_W-1] != opa[W-1]);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - directed self-checking bench for rca_seq_ctrl
module tb_rca_seq_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_assert = 0;
  int n_fail   = 0;

  rca_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_sum"},   32'(sum),   32'h0000);
    chk({tag, "_cout"},  32'(cout),  32'd0);
    chk({tag, "_ovf"},   32'(ovf),   32'd0);
  endtask

  // Called at a negedge where ready is high; returns at the negedge after the accept edge.
  task automatic launch(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsub);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    sub   = tsub;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
  endtask

  // Expects done exactly NIBBLES edges after the accept edge, with sum held until then.
  task automatic complete(input string tag, input logic [W-1:0] prev_sum,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    for (int k = 0; k < NIBBLES - 1; k++) begin
      @(negedge clk);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      chk({tag, "_hold"},   32'(sum),  32'(prev_sum));
    end
    @(negedge clk);
    chk({tag, "_done"},  32'(done),  32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_sum"},   32'(sum),   32'(exp_sum));
    chk({tag, "_cout"},  32'(cout),  32'(exp_cout));
    chk({tag, "_ovf"},   32'(ovf),   32'(exp_ovf));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;

    // 1. reset held for two edges
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle_zero("reset");

    // 2. adds
    launch("add1", 16'h1234, 16'h0FFF, 1'b0);
    complete("add1", 16'h0000, 16'h2233, 1'b0, 1'b0);
    @(negedge clk);
    chk("add1_pulse_end", 32'(done), 32'd0);
    chk("add1_idle_hold", 32'(sum), 32'h2233);

    launch("add2", 16'hFFFF, 16'h0001, 1'b0);
    complete("add2", 16'h2233, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);

    // 3. signed overflow add
    launch("ovf_add", 16'h7FFF, 16'h0001, 1'b0);
    complete("ovf_add", 16'h0000, 16'h8000, 1'b0, 1'b1);
    @(negedge clk);

    // 4. subtracts
    launch("sub1", 16'h0005, 16'h0007, 1'b1);
    complete("sub1", 16'h8000, 16'hFFFE, 1'b0, 1'b0);
    @(negedge clk);

    launch("sub2", 16'h8000, 16'h0001, 1'b1);
    complete("sub2", 16'hFFFE, 16'h7FFF, 1'b1, 1'b1);
    @(negedge clk);

    // 5a. start during RUN is ignored
    launch("hs1", 16'h0001, 16'h0002, 1'b0);
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    @(negedge clk);
    chk("hs1_ign_busy", 32'(busy), 32'd1);
    chk("hs1_ign_ready", 32'(ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("hs1_nodone", 32'(done), 32'd0);
    @(negedge clk);
    chk("hs1_done", 32'(done), 32'd1);
    chk("hs1_sum",  32'(sum),  32'h0003);
    chk("hs1_cout", 32'(cout), 32'd0);

    // 5b. back-to-back: start in the DONE cycle
    launch("hs2", 16'h0010, 16'h0020, 1'b0);
    chk("hs2_sum_hold0", 32'(sum), 32'h0003);
    complete("hs2", 16'h0003, 16'h0030, 1'b0, 1'b0);
    @(negedge clk);

    // 6. abort with one reset edge while idx == 2
    launch("abort", 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle_zero("abort");
    for (int k = 0; k < NIBBLES + 2; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    chk_idle_zero("abort_after");

    launch("fresh", 16'h0001, 16'h0001, 1'b0);
    complete("fresh", 16'h0000, 16'h0002, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Nibble-serial add/subtract sequencer built around one shared rca_4 ripple-carry adder. It accepts a multi-nibble operand pair with a start/ready handshake. It then drives the rca_4 one nibble per cycle, LSB nibble first, registering the carry between nibbles. It reports the full-width result, carry-out and signed overflow with a one-cycle done pulse. It is the control layer that turns the 4-bit adder into a W-bit ALU add/sub path.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; W = 4*NIBBLES; must be >= 2.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  request; accepted when start && ready
sub  input  1  0 = A+B, 1 = A-B; sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
ready  output  1  high in IDLE and DONE states
busy  output  1  high in RUN state
done  output  1  one-cycle pulse; result outputs valid from this cycle
sum  output  W  result, held until the next done
cout  output  1  carry out of MSB nibble; for sub, 1 = no borrow
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, nibble index=0, carry reg=0, operand/work regs=0. Outputs: ready=1, busy=0, done=0, sum=0, cout=0, ovf=0. Reset has priority over every other event, including mid-RUN; an aborted operation never produces done.
- States:
  - IDLE -> RUN on start.
  - RUN -> RUN while idx < NIBBLES-1.
  - RUN -> DONE when idx == NIBBLES-1.
  - DONE -> RUN on start; otherwise DONE -> IDLE.
- Accept (start && ready):
  - latch opA=a and opB = sub ? ~b : b.
  - carry reg = sub; idx = 0; latch sub.
  - start while busy is ignored and has no side effects.
- RUN cycle idx:
  - rca_4 inputs: A=opA[4*idx+:4], B=opB[4*idx+:4], Cin=carry reg.
  - work[4*idx+:4] <= S; carry reg <= Cout; idx++.
  - Exactly one rca_4 evaluation per cycle; the adder path is purely combinational between registers.
- Completion (RUN->DONE edge):
  - sum <= final work value, including the last nibble.
  - cout <= last Cout.
  - ovf <= (opA[W-1] == opB[W-1]) && (result[W-1] != opA[W-1]), with opB already inverted for sub.
- done=1 only in the DONE state.
- Latency: start sampled at edge T -> done high in the cycle after edge T+NIBBLES; NIBBLES+1 cycles from accept to done, i.e. 5 for the default.
- Back-to-back: start during DONE is accepted. The next done follows NIBBLES+1 cycles later, and sum holds the previous result until then.
- sum/cout/ovf change only at completion or reset, never during RUN.
- Operand inputs a/b/sub are don't-care except in the accept cycle.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NIBBLE_W=4 and the default NIBBLES.
- Sub-module: the existing rca_4 (itself built from full_adder_1), instantiated once.
- No other sub-module; the FSM, index counter and registers live in rca_seq_ctrl.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, including once mid-RUN -> ready=1, busy=0, done=0, sum=0x0000, cout=0, ovf=0 on the next cycle.
2. Add: a=0x1234, b=0x0FFF, sub=0 -> done exactly 5 cycles after accept, sum=0x2233, cout=0, ovf=0. Then a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0.
3. Signed overflow add: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
4. Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
5. Handshake:
   - start=1 with a=0xAAAA during RUN of a 0x0001+0x0002 job -> ignored; done gives sum=0x0003.
   - start in the DONE cycle with 0x0010+0x0020 -> busy next cycle, second done 5 cycles later with sum=0x0030; sum holds 0x0003 in between.
6. Abort: rst_n=0 for one edge during RUN idx=2 -> IDLE next cycle, no done pulse, outputs zero. A fresh 0x0001+0x0001 job then gives sum=0x0002.
